// File: rtl/umi_pkg.sv
// Shared UMI definitions: packet field positions, response opcodes, endpoint FSM
// states and the unpacked request record.
package umi_pkg;

    localparam int UMI_CMD_LSB   = 0;
    localparam int UMI_SIZE_LSB  = 8;
    localparam int UMI_DA_LO_LSB = 32;
    localparam int UMI_SA_LO_LSB = 64;
    localparam int UMI_DATA_LSB  = 96;
    localparam int UMI_SA_HI_LSB = 192;
    localparam int UMI_DA_HI_LSB = 224;

    localparam logic [7:0] UMI_RESP_READ = 8'h03;
    localparam logic [7:0] UMI_RESP_ERR  = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } umi_state_e;

    typedef struct packed {
        logic [7:0]  cmd;
        logic        write;
        logic [3:0]  size;
        logic [63:0] dstaddr;
        logic [63:0] srcaddr;
        logic [63:0] wdata;
        logic        legal;
    } umi_req_t;

    // Byte lanes touched by an access of 2^size bytes, before the offset shift.
    function automatic logic [7:0] umi_lane_mask(input logic [3:0] size);
        case (size)
            4'd0:    return 8'h01;
            4'd1:    return 8'h03;
            4'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] umi_align_mask(input logic [3:0] size);
        case (size)
            4'd0:    return 3'b000;
            4'd1:    return 3'b001;
            4'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [255:0] umi_pack_resp(input logic [7:0]  op,
                                                   input logic [3:0]  size,
                                                   input logic [63:0] src,
                                                   input logic [63:0] data);
        logic [255:0] p;
        p = '0;
        p[UMI_CMD_LSB +: 8]    = op;
        p[UMI_SIZE_LSB +: 4]   = size;
        p[UMI_DA_LO_LSB +: 32] = src[31:0];
        p[UMI_DA_HI_LSB +: 32] = src[63:32];
        p[UMI_DATA_LSB +: 64]  = data;
        return p;
    endfunction

endpackage

// File: rtl/umi_unpack.sv
// Combinational split of a 256-bit UMI request into its fields, plus the
// size/alignment legality check.
module umi_unpack
    import umi_pkg::*;
(
    input  logic [255:0] packet,
    output umi_req_t     req
);

    logic [3:0]  size;
    logic [63:0] dstaddr;

    assign size    = packet[UMI_SIZE_LSB +: 4];
    assign dstaddr = {packet[UMI_DA_HI_LSB +: 32], packet[UMI_DA_LO_LSB +: 32]};

    always_comb begin
        req         = '0;
        req.cmd     = packet[UMI_CMD_LSB +: 8];
        req.write   = packet[UMI_CMD_LSB];
        req.size    = size;
        req.dstaddr = dstaddr;
        req.srcaddr = {packet[UMI_SA_HI_LSB +: 32], packet[UMI_SA_LO_LSB +: 32]};
        req.wdata   = {packet[UMI_DATA_LSB + 32 +: 32], packet[UMI_DATA_LSB +: 32]};
        req.legal   = (size <= 4'd3) && ((dstaddr[2:0] & umi_align_mask(size)) == 3'b000);
    end

endmodule

// File: rtl/umi_mem_endpoint.sv
// Target-side UMI endpoint: one 64-bit memory access per request packet,
// posted writes, registered read/error responses.
module umi_mem_endpoint
    import umi_pkg::*;
#(
    parameter int AW = 64,
    parameter int UW = 256,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [UW-1:0] umi_out_packet,
    input  logic          umi_out_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wmask,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    localparam int NUM_LANES = DW / 8;

    umi_state_e    state;
    logic [UW-1:0] pkt_q;
    logic [UW-1:0] resp_q;
    umi_req_t      req_in;
    umi_req_t      req_q;
    logic [2:0]    off;
    logic [7:0]    lanes;
    logic [DW-1:0] rd_shift;
    logic [DW-1:0] rd_data;
    logic          unused_fields;

    // The incoming view decides legality at accept time; the latched view
    // drives the memory port and the read response.
    umi_unpack u_unpack_in (.packet(umi_in_packet), .req(req_in));
    umi_unpack u_unpack_q  (.packet(pkt_q),         .req(req_q));

    assign unused_fields = ^{req_in.cmd, req_in.dstaddr, req_in.wdata, req_q.cmd, req_q.legal};

    assign off      = req_q.dstaddr[2:0];
    assign lanes    = umi_lane_mask(req_q.size);
    assign rd_shift = mem_rdata >> {off, 3'b000};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign rd_data[8*i +: 8] = lanes[i] ? rd_shift[8*i +: 8] : 8'h00;
        end
    endgenerate

    assign umi_in_ready   = (state == ST_IDLE);
    assign umi_out_valid  = (state == ST_RESP);
    assign umi_out_packet = resp_q;
    assign mem_req        = (state == ST_MEM);
    assign mem_we         = req_q.write;
    assign mem_addr       = {req_q.dstaddr[AW-1:3], 3'b000};
    assign mem_wmask      = lanes << off;
    assign mem_wdata      = req_q.wdata << {off, 3'b000};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= ST_IDLE;
            pkt_q  <= '0;
            resp_q <= '0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (umi_in_valid) begin
                        pkt_q <= umi_in_packet;
                        if (req_in.legal) begin
                            state <= ST_MEM;
                        end else begin
                            err <= 1'b1;
                            // Illegal writes are dropped; illegal reads still owe a response.
                            if (!req_in.write) begin
                                resp_q <= umi_pack_resp(UMI_RESP_ERR, req_in.size,
                                                        req_in.srcaddr, '0);
                                state  <= ST_RESP;
                            end
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (req_q.write) begin
                            state <= ST_IDLE;
                        end else begin
                            resp_q <= umi_pack_resp(UMI_RESP_READ, req_q.size,
                                                    req_q.srcaddr, rd_data);
                            state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (umi_out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umi_mem_endpoint.sv
// Scoreboard bench for umi_mem_endpoint: expected memory accesses and response
// packets are queued at stimulus time and checked as the DUT produces them.
module tb_umi_mem_endpoint;

    typedef struct {
        logic [255:0] pkt;
        int           lat;
    } sb_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } mem_t;

    logic         clk = 1'b0;
    logic         nreset;
    logic         umi_in_valid;
    logic [255:0] umi_in_packet;
    logic         umi_in_ready;
    logic         umi_out_valid;
    logic [255:0] umi_out_packet;
    logic         umi_out_ready;
    logic         mem_req;
    logic         mem_we;
    logic [63:0]  mem_addr;
    logic [7:0]   mem_wmask;
    logic [63:0]  mem_wdata;
    logic         mem_ack;
    logic [63:0]  mem_rdata;
    logic         err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   err_cnt = 0;
    int   mreq_cnt = 0;
    int   ack_delay = 0;
    bit   ack_tie = 1'b0;
    sb_t  sb_q[$];
    mem_t mem_q[$];
    int   acc_q[$];

    umi_mem_endpoint #(.AW(64), .UW(256), .DW(64)) dut (
        .clk(clk), .nreset(nreset),
        .umi_in_valid(umi_in_valid), .umi_in_packet(umi_in_packet), .umi_in_ready(umi_in_ready),
        .umi_out_valid(umi_out_valid), .umi_out_packet(umi_out_packet), .umi_out_ready(umi_out_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] mk_req(input bit wr, input logic [3:0] size,
                                            input logic [63:0] da, input logic [63:0] sa,
                                            input logic [63:0] wd);
        logic [255:0] p;
        p = '0;
        p[7:0]     = wr ? 8'h01 : 8'h02;
        p[11:8]    = size;
        p[63:32]   = da[31:0];
        p[255:224] = da[63:32];
        p[95:64]   = sa[31:0];
        p[223:192] = sa[63:32];
        p[127:96]  = wd[31:0];
        p[159:128] = wd[63:32];
        return p;
    endfunction

    function automatic logic [255:0] exp_resp(input logic [7:0] op, input logic [3:0] size,
                                              input logic [63:0] sa, input logic [63:0] data);
        logic [255:0] p;
        p = '0;
        p[7:0]     = op;
        p[11:8]    = size;
        p[63:32]   = sa[31:0];
        p[255:224] = sa[63:32];
        p[159:96]  = data;
        return p;
    endfunction

    // Byte-by-byte reference of the read lane extraction.
    function automatic logic [63:0] exp_rdata(input logic [63:0] rd, input logic [2:0] off,
                                              input logic [3:0] size);
        logic [63:0] d;
        int n;
        d = '0;
        n = 1 << size;
        for (int b = 0; b < 8; b++)
            if (b < n && (int'(off) + b) < 8) d[8*b +: 8] = rd[8*(int'(off) + b) +: 8];
        return d;
    endfunction

    function automatic mem_t mk_mem(input bit wr, input logic [3:0] size, input logic [63:0] da,
                                    input logic [63:0] wd, input logic [63:0] rd);
        mem_t m;
        int off;
        int n;
        off     = int'(da[2:0]);
        n       = 1 << size;
        m.we    = wr;
        m.addr  = {da[63:3], 3'b000};
        m.wmask = '0;
        for (int b = 0; b < 8; b++) if (b >= off && b < off + n) m.wmask[b] = 1'b1;
        m.wdata = wd << (8 * off);
        m.rdata = rd;
        return m;
    endfunction

    task automatic send(input logic [255:0] p, input bit is_read);
        int n;
        n = 0;
        umi_in_valid  = 1'b1;
        umi_in_packet = p;
        @(negedge clk);
        while (!umi_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_accept", umi_in_ready, 1'b1);
        if (umi_in_ready && is_read) acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        umi_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(umi_in_ready && !umi_out_valid && !mem_req && sb_q.size() == 0
                     && mem_q.size() == 0) && n < 100);
        chk("idle_reached", n < 100, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Memory responder: checks each access against the expected queue and
    // holds the request fields stable until ack.
    initial begin
        mem_t cur;
        int   wcnt;
        wcnt    = 0;
        cur     = '{default: '0};
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req) begin
                mreq_cnt++;
                if (wcnt == 0) begin
                    chk("mem_req_expected", mem_q.size() != 0, 1'b1);
                    if (mem_q.size() != 0) cur = mem_q.pop_front();
                    mem_rdata = cur.rdata;
                end
                chk("mem_we", mem_we, cur.we);
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wmask", mem_wmask, cur.wmask);
                chk("mem_wdata", mem_wdata, cur.wdata);
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = ack_tie;
                wcnt    = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on the first valid cycle and
    // re-checks the held packet every cycle until the handshake.
    initial begin
        sb_t cur;
        bit  active;
        int  acc;
        active = 1'b0;
        cur    = '{pkt: '0, lat: -1};
        forever begin
            @(negedge clk);
            if (err) err_cnt++;
            if (!nreset) begin
                active = 1'b0;
            end else if (umi_out_valid) begin
                if (!active) begin
                    chk("resp_expected", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) cur = sb_q.pop_front();
                    acc = (acc_q.size() != 0) ? acc_q.pop_front() : cyc;
                    if (cur.lat >= 0) chk("resp_latency", cyc - acc, cur.lat);
                    active = 1'b1;
                end
                chk("resp_pkt", umi_out_packet, cur.pkt);
                if (umi_out_ready) active = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] da, sa, rd, wd;
        logic [3:0]  sz;
        int          e0, m0, n;
        bit          wr;

        nreset = 1'b0;
        umi_in_valid = 1'b0;
        umi_in_packet = '0;
        umi_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", umi_in_ready, 1'b1);
        chk("rst_out_valid", umi_out_valid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Posted write, one wait state.
        ack_delay = 1;
        mem_q.push_back('{we: 1'b1, addr: 64'h1000, wmask: 8'hF0,
                          wdata: 64'hDEADBEEF_00000000, rdata: 64'h0});
        send(mk_req(1'b1, 4'd2, 64'h1004, 64'h0, 64'hDEADBEEF), 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(mem_req && mem_ack) && n < 20);
        chk("wr_ack_seen", mem_req && mem_ack, 1'b1);
        @(negedge clk);
        chk("wr_ready_after_ack", umi_in_ready, 1'b1);
        chk("wr_no_resp", umi_out_valid, 1'b0);
        wait_idle();

        // Read with three wait states.
        ack_delay = 3;
        mem_q.push_back('{we: 1'b0, addr: 64'h2000, wmask: 8'hC0,
                          wdata: 64'h0, rdata: 64'h1234_5678_9ABC_DEF0});
        sb_q.push_back('{pkt: exp_resp(8'h03, 4'd1, 64'h0000_0001_0000_0040, 64'h1234), lat: 5});
        send(mk_req(1'b0, 4'd1, 64'h2006, 64'h0000_0001_0000_0040, 64'h0), 1'b1);
        wait_idle();

        // Backpressure on the response.
        ack_delay = 0;
        umi_out_ready = 1'b0;
        rd = 64'hA5A5_0102_0304_5A5A;
        mem_q.push_back(mk_mem(1'b0, 4'd3, 64'h4000, 64'h0, rd));
        sb_q.push_back('{pkt: exp_resp(8'h03, 4'd3, 64'h55, rd), lat: 2});
        send(mk_req(1'b0, 4'd3, 64'h4000, 64'h55, 64'h0), 1'b1);
        n = 0;
        while (!umi_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", umi_out_valid, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", umi_in_ready, 1'b0);
            chk("bp_valid_held", umi_out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        umi_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after_hs", umi_in_ready, 1'b1);
        chk("bp_valid_dropped", umi_out_valid, 1'b0);
        @(posedge clk);
        #1;
        wait_idle();

        // Illegal requests: misaligned read, misaligned write, oversize read.
        e0 = err_cnt;
        sb_q.push_back('{pkt: exp_resp(8'h0F, 4'd3, 64'h0000_0002_0000_0080, 64'h0), lat: 1});
        send(mk_req(1'b0, 4'd3, 64'h3004, 64'h0000_0002_0000_0080, 64'h0), 1'b1);
        wait_idle();
        chk("err_misaligned_read", err_cnt - e0, 1);
        e0 = err_cnt;
        send(mk_req(1'b1, 4'd2, 64'h3002, 64'h0, 64'h1111_2222), 1'b0);
        wait_idle();
        chk("err_misaligned_write", err_cnt - e0, 1);
        e0 = err_cnt;
        sb_q.push_back('{pkt: exp_resp(8'h0F, 4'd4, 64'h99, 64'h0), lat: 1});
        send(mk_req(1'b0, 4'd4, 64'h5000, 64'h99, 64'h0), 1'b1);
        wait_idle();
        chk("err_oversize_read", err_cnt - e0, 1);

        // Zero-wait back-to-back reads with mem_ack tied high.
        ack_tie = 1'b1;
        ack_delay = 0;
        m0 = mreq_cnt;
        for (int i = 0; i < 4; i++) begin
            sz = 4'($urandom_range(0, 3));
            da = {32'h0, $urandom} & ~64'(int'(umi_pkg::umi_align_mask(sz)));
            sa = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            mem_q.push_back(mk_mem(1'b0, sz, da, 64'h0, rd));
            sb_q.push_back('{pkt: exp_resp(8'h03, sz, sa, exp_rdata(rd, da[2:0], sz)), lat: 2});
            send(mk_req(1'b0, sz, da, sa, 64'h0), 1'b1);
        end
        wait_idle();
        chk("zw_mem_req_cycles", mreq_cnt - m0, 4);
        ack_tie = 1'b0;

        // Mixed random traffic with random ack delays.
        for (int i = 0; i < 8; i++) begin
            ack_delay = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            sz = 4'($urandom_range(0, 3));
            da = {$urandom, $urandom} & ~64'(int'(umi_pkg::umi_align_mask(sz)));
            sa = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            mem_q.push_back(mk_mem(wr, sz, da, wd, rd));
            if (!wr) sb_q.push_back('{pkt: exp_resp(8'h03, sz, sa, exp_rdata(rd, da[2:0], sz)),
                                      lat: 2 + ack_delay});
            send(mk_req(wr, sz, da, sa, wd), !wr);
            wait_idle();
        end

        // Reset in the middle of a stalled access.
        ack_delay = 20;
        mem_q.push_back(mk_mem(1'b1, 4'd3, 64'h7000, 64'hCAFE, 64'h0));
        send(mk_req(1'b1, 4'd3, 64'h7000, 64'h0, 64'hCAFE), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_req_active", mem_req, 1'b1);
        nreset = 1'b0;
        ack_tie = 1'b1;
        #1;
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_out_valid", umi_out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_in_ready", umi_in_ready, 1'b1);
        chk("rst_mid_no_req", mem_req, 1'b0);
        ack_tie = 1'b0;

        chk("sb_drained", sb_q.size(), 0);
        chk("mem_drained", mem_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
